// File: rtl/mem_access_unit_pkg.sv
// mem_pkg: shared encodings for the MEM-stage data memory access unit.
//   - Access size encodings carried on ByteSel_In (2'b11 behaves as a word).
//   - FSM state encoding of the request/acknowledge sequencer.
//   - TIMEOUT_DATA: load result returned when an access is aborted by the
//     ack timeout (only reachable with MEM_ACCESS_TIMEOUT_EN defined).
package mem_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/acknowledge bus between the MEM stage and a
// variable-latency data memory.
//   Mem_Req   request, held until Mem_Ack
//   Mem_We    1 = write
//   Mem_Addr  word-aligned byte address (ADDR_W bits)
//   Mem_BE    byte enables, bit3 = bits [31:24] (big-endian lane 0)
//   Mem_WData lane-replicated store data
//   Mem_Ack   completion from memory
//   Mem_RData read word, valid together with Mem_Ack
// Modports: master = access unit side, slave = memory side.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              Mem_Req;
  logic              Mem_We;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [3:0]        Mem_BE;
  logic [31:0]       Mem_WData;
  logic              Mem_Ack;
  logic [31:0]       Mem_RData;

  modport master (
    output Mem_Req, Mem_We, Mem_Addr, Mem_BE, Mem_WData,
    input  Mem_Ack, Mem_RData
  );

  modport slave (
    input  Mem_Req, Mem_We, Mem_Addr, Mem_BE, Mem_WData,
    output Mem_Ack, Mem_RData
  );
endinterface

// File: rtl/mem_access_unit_load_formatter.sv
// load_formatter: purely combinational load data formatting.
//   rdata  in  32  raw word from memory
//   offset in  2   byte offset within the word (0 = bits [31:24])
//   size   in  2   SZ_BYTE / SZ_HALF / anything else = word
//   zext   in  1   1 = zero-extend, 0 = sign-extend
//   result out 32  right-justified, extended load value
module load_formatter
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        zext,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // Big-endian lanes: offset 0 is the most significant byte.
    case (offset)
      2'd0:    byte_sel = rdata[31:24];
      2'd1:    byte_sel = rdata[23:16];
      2'd2:    byte_sel = rdata[15:8];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = offset[1] ? rdata[15:0] : rdata[31:16];

    case (size)
      SZ_BYTE: result = zext ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: result = zext ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data memory access sequencer.
// Takes the EX/MEM register outputs, issues one request/acknowledge
// transaction per load/store on a variable-latency memory, stalls the
// pipeline until the ack, and formats load data for MEM/WB.
//
// Ports:
//   Clock, Reset       clock and synchronous active-high reset
//   MemRead_In         load request
//   MemWrite_In        store request (wins if both are set)
//   ByteSel_In         size: 00 word, 01 byte, 10 half, 11 word
//   L16B_In            bit0: 1 zero-extend, 0 sign-extend (bit1 ignored)
//   ALUResult_In       effective byte address
//   WriteData_In       right-justified store data
//   mem                memory bus (mem_access_unit_if.master)
//   ReadData_Out       formatted load result, held until next completed load
//   Stall              hold the upstream pipeline registers
//   AddrErr            one-cycle pulse on a misaligned access (no request)
//   Timeout            sticky ack timeout flag
//
// Build option: define MEM_ACCESS_TIMEOUT_EN to abort a request after
// TIMEOUT_CYCLES request cycles without ack. Without it REQ waits
// indefinitely and Timeout is tied low.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                MemRead_In,
  input  logic                MemWrite_In,
  input  logic [1:0]          ByteSel_In,
  input  logic [1:0]          L16B_In,
  input  logic [31:0]         ALUResult_In,
  input  logic [31:0]         WriteData_In,
  mem_access_unit_if.master   mem,
  output logic [31:0]         ReadData_Out,
  output logic                Stall,
  output logic                AddrErr,
  output logic                Timeout
);

  state_t      state;
  logic        access;
  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        misaligned;
  logic        start;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;

  // Attributes of the in-flight access, latched when the request starts.
  logic [1:0]  size_q;
  logic [1:0]  offset_q;
  logic        zext_q;
  logic        read_q;
  logic [31:0] fmt_data;

  // Reserved extension bit has no function.
  logic unused_l16b;
  assign unused_l16b = L16B_In[1];

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign Timeout = 1'b0;
`endif

  always_comb begin
    access     = MemRead_In | MemWrite_In;
    is_byte    = (ByteSel_In == SZ_BYTE);
    is_half    = (ByteSel_In == SZ_HALF);
    is_word    = !is_byte && !is_half;
    misaligned = (is_half && ALUResult_In[0]) ||
                 (is_word && (ALUResult_In[1:0] != 2'b00));

    // Reset gates the IDLE-side decisions so no new access can start
    // or flag an error in a reset cycle.
    start   = (state == IDLE) && access && !misaligned && !Reset;
    AddrErr = (state == IDLE) && access && misaligned && !Reset;
    Stall   = start || (state == REQ);

    case (ByteSel_In)
      SZ_BYTE: begin
        be_next    = 4'b1000 >> ALUResult_In[1:0];
        wdata_next = {4{WriteData_In[7:0]}};
      end
      SZ_HALF: begin
        be_next    = ALUResult_In[1] ? 4'b0011 : 4'b1100;
        wdata_next = {2{WriteData_In[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = WriteData_In;
      end
    endcase
  end

  load_formatter u_load_formatter (
    .rdata  (mem.Mem_RData),
    .offset (offset_q),
    .size   (size_q),
    .zext   (zext_q),
    .result (fmt_data)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state         <= IDLE;
      mem.Mem_Req   <= 1'b0;
      mem.Mem_We    <= 1'b0;
      mem.Mem_Addr  <= '0;
      mem.Mem_BE    <= 4'b0000;
      mem.Mem_WData <= 32'h0;
      ReadData_Out  <= 32'h0;
      size_q        <= SZ_WORD;
      offset_q      <= 2'b00;
      zext_q        <= 1'b0;
      read_q        <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      wait_cnt      <= 8'd0;
      Timeout       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state         <= REQ;
            mem.Mem_Req   <= 1'b1;
            mem.Mem_We    <= MemWrite_In;
            mem.Mem_Addr  <= ADDR_W'({ALUResult_In[31:2], 2'b00});
            mem.Mem_BE    <= be_next;
            mem.Mem_WData <= wdata_next;
            size_q        <= ByteSel_In;
            offset_q      <= ALUResult_In[1:0];
            zext_q        <= L16B_In[0];
            // A simultaneous store takes priority; nothing is captured.
            read_q        <= MemRead_In && !MemWrite_In;
`ifdef MEM_ACCESS_TIMEOUT_EN
            wait_cnt      <= 8'd0;
`endif
          end
        end
        REQ: begin
          if (mem.Mem_Ack) begin
            state       <= DONE;
            mem.Mem_Req <= 1'b0;
            if (read_q) ReadData_Out <= fmt_data;
          end
`ifdef MEM_ACCESS_TIMEOUT_EN
          else if (wait_cnt == TIMEOUT_LAST) begin
            state       <= DONE;
            mem.Mem_Req <= 1'b0;
            Timeout     <= 1'b1;
            if (read_q) ReadData_Out <= TIMEOUT_DATA;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        // One non-stalled cycle lets the pipeline advance past the
        // held instruction; it is never re-issued.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit.
// Stimulus pushes expected bus transactions and point probes into queues;
// a monitor on the falling edge pops and compares them against the DUT.
module tb_mem_access_unit;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  logic        Clock = 1'b0;
  logic        Reset;
  logic        MemRead_In, MemWrite_In;
  logic [1:0]  ByteSel_In, L16B_In;
  logic [31:0] ALUResult_In, WriteData_In;
  logic [31:0] ReadData_Out;
  logic        Stall, AddrErr, Timeout;

  mem_access_unit_if #(.ADDR_W(32)) mif ();

  mem_access_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .MemRead_In   (MemRead_In),
    .MemWrite_In  (MemWrite_In),
    .ByteSel_In   (ByteSel_In),
    .L16B_In      (L16B_In),
    .ALUResult_In (ALUResult_In),
    .WriteData_In (WriteData_In),
    .mem          (mif),
    .ReadData_Out (ReadData_Out),
    .Stall        (Stall),
    .AddrErr      (AddrErr),
    .Timeout      (Timeout)
  );

  always #5 Clock = ~Clock;

  typedef enum int {K_RDATA, K_REQ, K_STALL, K_ADDRERR, K_TIMEOUT, K_BE, K_ADDR, K_WE, K_WDATA, K_TXQ} kind_t;

  typedef struct {
    kind_t       kind;
    logic [31:0] exp;
    string       name;
  } probe_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rd;
    int          stall;
  } txn_t;

  probe_t probe_q[$];
  txn_t   txn_q[$];
  int     errors = 0;
  int     checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic probe(input kind_t k, input logic [31:0] exp, input string name);
    probe_t p;
    p.kind = k; p.exp = exp; p.name = name;
    probe_q.push_back(p);
  endtask

  // Monitor: all comparisons happen here, on the falling edge.
  initial begin
    probe_t      p;
    txn_t        cur;
    logic [31:0] got;
    bit          pend = 0;
    int          stall_run = 0;
    forever begin
      @(negedge Clock);
      while (probe_q.size() > 0) begin
        p = probe_q.pop_front();
        case (p.kind)
          K_RDATA:   got = ReadData_Out;
          K_REQ:     got = {31'b0, mif.Mem_Req};
          K_STALL:   got = {31'b0, Stall};
          K_ADDRERR: got = {31'b0, AddrErr};
          K_TIMEOUT: got = {31'b0, Timeout};
          K_BE:      got = {28'b0, mif.Mem_BE};
          K_ADDR:    got = mif.Mem_Addr;
          K_WE:      got = {31'b0, mif.Mem_We};
          K_WDATA:   got = mif.Mem_WData;
          default:   got = 32'(txn_q.size());
        endcase
        chk(p.name, got, p.exp);
      end
      if (pend) begin
        chk("done_stall", {31'b0, Stall}, 32'd0);
        chk("done_req", {31'b0, mif.Mem_Req}, 32'd0);
        chk("read_data", ReadData_Out, cur.rd);
        chk("stall_cycles", 32'(stall_run), 32'(cur.stall));
        pend = 0;
      end
      if (mif.Mem_Req && mif.Mem_Ack) begin
        if (txn_q.size() == 0) begin
          chk("expected_txn_count", 32'(txn_q.size()), 32'd1);
        end else begin
          cur = txn_q.pop_front();
          chk("mem_we", {31'b0, mif.Mem_We}, {31'b0, cur.we});
          chk("mem_addr", mif.Mem_Addr, cur.addr);
          chk("mem_be", {28'b0, mif.Mem_BE}, {28'b0, cur.be});
          chk("mem_wdata", mif.Mem_WData, cur.wdata);
          chk("req_stall", {31'b0, Stall}, 32'd1);
          pend = 1;
        end
      end
      if (Stall) stall_run++;
      else       stall_run = 0;
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic clear_inputs();
    MemRead_In = 0; MemWrite_In = 0; ByteSel_In = 2'b00; L16B_In = 2'b00;
    ALUResult_In = 32'h0; WriteData_In = 32'h0;
  endtask

  // One access: inputs held from the IDLE cycle through DONE; ack given in
  // REQ cycle number ackc (1 = first REQ cycle).
  task automatic do_access(input logic rd, input logic wr, input logic [1:0] bs, input logic [1:0] l16,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdat,
                           input int ackc, input logic [31:0] eaddr, input logic [3:0] ebe,
                           input logic [31:0] ewd, input logic [31:0] erd);
    txn_t t;
    t.we = wr; t.addr = eaddr; t.be = ebe; t.wdata = ewd; t.rd = erd; t.stall = ackc + 1;
    txn_q.push_back(t);
    MemRead_In = rd; MemWrite_In = wr; ByteSel_In = bs; L16B_In = l16;
    ALUResult_In = addr; WriteData_In = wd;
    tick();
    for (int i = 1; i < ackc; i++) tick();
    mif.Mem_Ack = 1; mif.Mem_RData = rdat;
    tick();
    mif.Mem_Ack = 0; mif.Mem_RData = 32'h5A5A5A5A;
    tick();
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    mif.Mem_Ack = 0; mif.Mem_RData = 32'h0;
    Reset = 1;
    tick(); tick();
    Reset = 0;
    probe(K_RDATA, 32'h0, "reset_rdata");
    probe(K_REQ, 32'h0, "reset_req");
    probe(K_STALL, 32'h0, "reset_stall");
    probe(K_BE, 32'h0, "reset_be");
    probe(K_ADDR, 32'h0, "reset_addr");
    probe(K_WE, 32'h0, "reset_we");
    probe(K_WDATA, 32'h0, "reset_wdata");
    probe(K_TIMEOUT, 32'h0, "reset_timeout");
    tick();

    // Word load, ack in third REQ cycle -> 4 stall cycles.
    do_access(1, 0, 2'b00, 2'b00, 32'h100, 32'h0, 32'h11223344, 3, 32'h100, 4'b1111, 32'h0, 32'h11223344);
    // Signed byte load from lane 3.
    do_access(1, 0, 2'b01, 2'b00, 32'h103, 32'h0, 32'h000000F0, 1, 32'h100, 4'b0001, 32'h0, 32'hFFFFFFF0);
    // Same, zero-extended.
    do_access(1, 0, 2'b01, 2'b01, 32'h103, 32'h0, 32'h000000F0, 1, 32'h100, 4'b0001, 32'h0, 32'h000000F0);
    // Halfword store: read data presented with ack must not be captured.
    do_access(0, 1, 2'b10, 2'b00, 32'h202, 32'h0000ABCD, 32'h55555555, 2, 32'h200, 4'b0011, 32'hABCDABCD, 32'h000000F0);
    // Byte store lane 1.
    do_access(0, 1, 2'b01, 2'b00, 32'h101, 32'h123456A5, 32'h0, 1, 32'h100, 4'b0100, 32'hA5A5A5A5, 32'h000000F0);
    // Signed halfword load, lower half.
    do_access(1, 0, 2'b10, 2'b00, 32'h106, 32'h0, 32'h12348001, 1, 32'h104, 4'b0011, 32'h0, 32'hFFFF8001);
    // Zero-extended halfword load, upper half; L16B bit1 ignored.
    do_access(1, 0, 2'b10, 2'b11, 32'h104, 32'h0, 32'h80011234, 2, 32'h104, 4'b1100, 32'h0, 32'h00008001);
    // Read and write together: the write wins, no capture.
    do_access(1, 1, 2'b00, 2'b00, 32'h300, 32'hCAFEF00D, 32'h99999999, 1, 32'h300, 4'b1111, 32'hCAFEF00D, 32'h00008001);
    // ByteSel 11 behaves as a word.
    do_access(1, 0, 2'b11, 2'b00, 32'h10C, 32'h0, 32'hA1B2C3D4, 1, 32'h10C, 4'b1111, 32'h0, 32'hA1B2C3D4);

    // Misaligned word load: one-cycle AddrErr, no stall, no request.
    MemRead_In = 1; ByteSel_In = 2'b00; ALUResult_In = 32'h101;
    probe(K_ADDRERR, 32'd1, "misalign_word_err");
    probe(K_STALL, 32'd0, "misalign_word_stall");
    tick();
    clear_inputs();
    probe(K_ADDRERR, 32'd0, "misalign_word_err_end");
    probe(K_REQ, 32'd0, "misalign_word_req");
    tick();
    // Misaligned halfword store.
    MemWrite_In = 1; ByteSel_In = 2'b10; ALUResult_In = 32'h203; WriteData_In = 32'h1111;
    probe(K_ADDRERR, 32'd1, "misalign_half_err");
    probe(K_STALL, 32'd0, "misalign_half_stall");
    tick();
    clear_inputs();
    probe(K_REQ, 32'd0, "misalign_half_req");
    probe(K_RDATA, 32'hA1B2C3D4, "misalign_rdata_kept");
    tick();

    // Reset during REQ, then a late ack.
    MemRead_In = 1; ByteSel_In = 2'b00; ALUResult_In = 32'h400;
    tick();
    probe(K_REQ, 32'd1, "midreq_req");
    probe(K_STALL, 32'd1, "midreq_stall");
    probe(K_ADDR, 32'h400, "midreq_addr");
    tick();
    Reset = 1;
    clear_inputs();
    tick();
    Reset = 0;
    probe(K_REQ, 32'd0, "after_reset_req");
    probe(K_STALL, 32'd0, "after_reset_stall");
    probe(K_RDATA, 32'h0, "after_reset_rdata");
    probe(K_BE, 32'h0, "after_reset_be");
    probe(K_ADDR, 32'h0, "after_reset_addr");
    tick();
    mif.Mem_Ack = 1; mif.Mem_RData = 32'h77777777;
    probe(K_REQ, 32'd0, "late_ack_req");
    probe(K_STALL, 32'd0, "late_ack_stall");
    tick();
    mif.Mem_Ack = 0;
    probe(K_RDATA, 32'h0, "late_ack_rdata");
    tick();

`ifdef MEM_ACCESS_TIMEOUT_EN
    // No ack: abort after four REQ cycles.
    MemRead_In = 1; ByteSel_In = 2'b00; ALUResult_In = 32'h500;
    tick();
    probe(K_REQ, 32'd1, "to_req");
    tick(); tick(); tick();
    probe(K_STALL, 32'd1, "to_req4_stall");
    probe(K_TIMEOUT, 32'd0, "to_req4_flag");
    tick();
    probe(K_STALL, 32'd0, "to_done_stall");
    probe(K_REQ, 32'd0, "to_done_req");
    probe(K_TIMEOUT, 32'd1, "to_flag");
    probe(K_RDATA, 32'hDEADBEEF, "to_rdata");
    tick();
    clear_inputs();
    tick(); tick();
    probe(K_TIMEOUT, 32'd1, "to_sticky");
    probe(K_REQ, 32'd0, "to_idle_req");
`else
    probe(K_TIMEOUT, 32'd0, "timeout_tied_low");
`endif
    probe(K_TXQ, 32'd0, "txn_queue_drained");
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Turns MemRead/MemWrite, ByteSel, L16B, ALUResult (address) and WriteData into a request/acknowledge transaction on a variable-latency data memory.
- Stalls the pipeline until the memory acknowledges, then formats load data (lane select, sign/zero extension) for the MEM/WB register.
- Big-endian byte numbering: offset 0 = bits [31:24].

Parameters:
- ADDR_W, 32, address width presented to memory.
- TIMEOUT_CYCLES, 255, ack wait limit (used only with the optional feature).

Ports:
- Clock  in  1  clock; all state updates on posedge.
- Reset  in  1  reset, synchronous, active-high.
- MemRead_In  in  1  load request from EX/MEM.
- MemWrite_In  in  1  store request from EX/MEM.
- ByteSel_In  in  2  access size: 00 word, 01 byte, 10 halfword, 11 treated as word.
- L16B_In  in  2  load extension: bit0=1 zero-extend, bit0=0 sign-extend; bit1 reserved, ignored.
- ALUResult_In  in  32  effective byte address.
- WriteData_In  in  32  store data, right-justified.
- Mem_Req  out  1  memory request.
- Mem_We  out  1  1 = write.
- Mem_Addr  out  ADDR_W  word-aligned address ({addr[31:2],2'b00}).
- Mem_BE  out  4  byte enables; bit3 = bits [31:24].
- Mem_WData  out  32  lane-replicated store data.
- Mem_Ack  in  1  memory completion.
- Mem_RData  in  32  read word, valid with Mem_Ack.
- ReadData_Out  out  32  formatted load result.
- Stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM.
- AddrErr  out  1  misaligned-access pulse.
- Timeout  out  1  sticky ack timeout (optional feature only).

Behaviour:
- FSM states: IDLE, REQ, DONE.
- Access = MemRead_In | MemWrite_In. If both are set, the write wins (Mem_We=1) and no read data is captured.
- Misaligned conditions:
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0.
- IDLE, access and aligned:
  - Stall=1 combinationally.
  - Latch Mem_Addr, Mem_We, Mem_BE, Mem_WData, size/extension and byte offset.
  - Go to REQ.
- IDLE, access and misaligned:
  - AddrErr=1 for that cycle (combinational).
  - No request issued; Stall=0; stay IDLE.
- REQ:
  - Mem_Req=1 and Stall=1.
  - Request fields are held stable until Mem_Ack.
  - On Mem_Ack: if read, register the formatted data into ReadData_Out; go to DONE. Mem_Req deasserts from the next cycle.
- DONE:
  - Stall=0 for exactly one cycle, so the pipeline advances.
  - Go to IDLE unconditionally; the held instruction is never re-issued.
- Minimum access latency is 2 cycles of Stall (ack arrives in the first REQ cycle).
- Byte enables:
  - byte: BE = 4'b1000 >> addr[1:0]; WData = {4{wd[7:0]}}.
  - half: BE = addr[1] ? 0011 : 1100; WData = {2{wd[15:0]}}.
  - word: BE = 1111; WData = wd.
- Load formatting:
  - Select the byte or half from Mem_RData by latched offset.
  - Extend to 32 bits per L16B bit0.
- ReadData_Out holds its value until the next completed load. Stores leave it unchanged.
- Mem_Ack outside REQ is ignored.
- Reset, at any time including mid-REQ:
  - next state IDLE;
  - Mem_Req, Mem_We, Mem_BE, Mem_Addr, Mem_WData, ReadData_Out, Timeout all 0;
  - Stall is 0 from the following cycle.
  - A late ack after reset is ignored.

Optional Feature:
- Macro: MEM_ACCESS_TIMEOUT_EN.
- Defined:
  - 8-bit wait counter, cleared on entering REQ, increments each REQ cycle without ack.
  - When the count reaches TIMEOUT_CYCLES: abort to DONE, set Timeout=1 (sticky until Reset), ReadData_Out=32'hDEADBEEF for a read.
- Undefined: no counter; REQ waits indefinitely; Timeout tied 0.

Decomposition:
- Shared package mem_pkg:
  - size encodings SZ_WORD=2'b00, SZ_BYTE=2'b01, SZ_HALF=2'b10;
  - FSM state encoding (IDLE=2'd0, REQ=2'd1, DONE=2'd2);
  - TIMEOUT_DATA constant 32'hDEADBEEF.
- One sub-module: load_formatter, purely combinational (rdata, offset, size, zext -> 32-bit result).
- Byte-enable/replication logic stays inline.

Test Plan:
- Word load addr 0x100, Mem_RData=0x11223344, ack after 3 cycles -> Mem_BE=1111, Stall high 4 cycles, low in DONE, ReadData_Out=0x11223344.
- Byte load signed addr 0x103, Mem_RData=0x000000F0, ack immediate -> Mem_BE=0001, ReadData_Out=0xFFFFFFF0; same with L16B_In=01 -> 0x000000F0.
- Halfword store addr 0x202, WriteData_In=0x0000ABCD -> Mem_We=1, Mem_BE=0011, Mem_WData=0xABCDABCD, Mem_Addr=0x200, ReadData_Out unchanged.
- Word load addr 0x101 -> AddrErr pulse 1 cycle, Mem_Req never asserts, Stall=0.
- Reset asserted in REQ, then ack 2 cycles later -> IDLE, Mem_Req=0 next cycle, ReadData_Out=0, ack ignored.
- With MEM_ACCESS_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> after 4 REQ cycles: DONE, Timeout=1 sticky, ReadData_Out=0xDEADBEEF.
